alu_op_seq: RTL
===============

# alu_op_seq

Parametrised successor to the combinational ALU control decoder. It keeps the existing ALUOp/funct decoding and adds a sequencer that executes multi-cycle R-type operations on a DATA_W datapath. Multiply always runs multi-cycle; divide does so when it is compiled in. The block sits in EX beside the ALU and drives a stall to the hazard unit while an iterative operation is in flight.

## Interface
- DATA_W, 32: operand/result width; legal range 4..64.
- CNT_W, $clog2(DATA_W+1): iteration counter width; derived, not overridden.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  EX stage holds a valid instruction this cycle.
- ALUOp_i  in  2  00 add, 01 sub, 10 or, 11 R-type.
- funct_i  in  6  R-type function field.
- rs_data_i  in  DATA_W  operand A (multiplicand / dividend).
- rt_data_i  in  DATA_W  operand B (multiplier / divisor).
- ALUCtrl_o  out  3  ALU control code; combinational.
- illegal_o  out  1  combinational; R-type with an unsupported funct.
- stall_o  out  1  hold the pipeline; combinational from state and inputs.
- done_o  out  1  one-cycle pulse; seq_result_o is valid.
- seq_result_o  out  DATA_W  result of the last multi-cycle operation.

## Operation
- Decode for ALUOp 00 / 01 / 10 produces 010 / 110 / 001 respectively.
- R-type funct decode:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - 011000 (mul) -> 011
  - 011010 (div, only with ALU_SEQ_DIV_EN) -> 100
- Any other R-type funct gives 010 and illegal_o=1. illegal_o is 0 for non-R-type ALUOp values.
- Multi-cycle op (seq_op): valid_i=1, ALUOp_i=11, and funct is mul, or funct is div when division is enabled.
- FSM states:
  - IDLE: if seq_op, latch operands, load counter with DATA_W, go to BUSY.
  - BUSY: one iteration per cycle; decrement counter; when counter reaches 1, go to DONE.
  - DONE: done_o=1 and seq_result_o updated. If seq_op is present, accept it and go to BUSY; otherwise go to IDLE.
- Multiply is unsigned shift-add.
  - Each iteration: if the multiplier LSB is 1, add the multiplicand to the accumulator; shift the multiplicand left and the multiplier right.
  - Result is the low DATA_W bits of the product (correct for two's-complement inputs).
- Divide is unsigned restoring, one quotient bit per iteration. Result is the quotient.
- Divide by zero: quotient is all ones; the iterations still run so latency is fixed.
- seq_result_o holds its value until the next DONE. In BUSY, valid_i, funct_i and operand changes are ignored.
- stall_o = (IDLE or DONE) and seq_op, or state is BUSY.
  - stall_o is low in a DONE cycle with no new seq_op, so EX/MEM captures seq_result_o that cycle.

## Timing
- Reset (rst_i=0 at a clock edge): state IDLE, counter 0, accumulator and operand registers 0, seq_result_o 0, done_o 0, stall_o 0. Reset mid-BUSY aborts with no done_o.
- Latency: op accepted in cycle T, BUSY T+1..T+DATA_W, done_o in T+DATA_W+1. Total DATA_W+2 cycles in EX.
- Back-to-back: a seq_op present during DONE is accepted in that cycle. It gives done_o for the first op and stall_o=1 for the second.
- ALUCtrl_o and illegal_o are combinational from ALUOp_i/funct_i in every state, including reset.

## Configuration
- ALU_SEQ_DIV_EN defined: funct 011010 is a seq_op with DATA_W+2 cycle latency, and ALUCtrl_o=100.
- ALU_SEQ_DIV_EN undefined: no divider logic. Funct 011010 gives ALUCtrl_o=010, illegal_o=1, and no stall.

## Test plan
- DATA_W=32, mul 7×6 issued in cycle 0 -> stall_o high cycles 0..32; done_o and seq_result_o=42 at cycle 33 with stall_o low.
- mul 0xFFFFFFFF×2 -> seq_result_o=0xFFFFFFFE. mul 0x80000000×0x80000000 -> 0x00000000.
- Reset at cycle 10 of a mul -> cycle 11: stall_o=0, seq_result_o=0, no done_o. A mul issued afterwards completes normally.
- Two muls back-to-back (3×5, then 4×4 presented during DONE) -> done_o with 15 at cycle 33, then done_o with 16 at cycle 66.
- With ALU_SEQ_DIV_EN: 100÷7 -> 14; 5÷0 -> 0xFFFFFFFF. Without the macro: funct 011010 -> illegal_o=1, ALUCtrl_o=010, no stall.
- Decode sweep: ALUOp 00/01/10 -> 010/110/001. R-type 100100 -> 000, 101010 -> 111, 111111 -> 010 with illegal_o=1.

Source files
------------

// File: rtl/alu_op_seq.sv
// ALU control decoder with a multi-cycle sequencer for R-type multiply (and divide when
// the ALU_SEQ_DIV_EN macro is defined). Stalls the pipeline while an iteration is in flight.
module alu_op_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    output logic [2:0]        ALUCtrl_o,
    output logic              illegal_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] seq_result_o
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [5:0] FUNCT_DIV = 6'b011010;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              done_q, done_d;
    logic              seq_op_s;
    logic              is_div_s;

    logic [DATA_W-1:0] mul_acc_s;
    logic [DATA_W-1:0] mul_a_s;
    logic [DATA_W-1:0] mul_b_s;

    // ALU control decode, purely combinational from ALUOp/funct in every state
    always_comb begin
        ALUCtrl_o = 3'b010;
        illegal_o = 1'b0;
        case (ALUOp_i)
            2'b00: ALUCtrl_o = 3'b010;
            2'b01: ALUCtrl_o = 3'b110;
            2'b10: ALUCtrl_o = 3'b001;
            2'b11: begin
                case (funct_i)
                    FUNCT_ADD: ALUCtrl_o = 3'b010;
                    FUNCT_SUB: ALUCtrl_o = 3'b110;
                    FUNCT_AND: ALUCtrl_o = 3'b000;
                    FUNCT_OR:  ALUCtrl_o = 3'b001;
                    FUNCT_SLT: ALUCtrl_o = 3'b111;
                    FUNCT_MUL: ALUCtrl_o = 3'b011;
`ifdef ALU_SEQ_DIV_EN
                    FUNCT_DIV: ALUCtrl_o = 3'b100;
`endif
                    default: begin
                        ALUCtrl_o = 3'b010;
                        illegal_o = 1'b1;
                    end
                endcase
            end
            default: begin
                ALUCtrl_o = 3'b010;
                illegal_o = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_DIV_EN
    assign is_div_s = (funct_i == FUNCT_DIV);
`else
    assign is_div_s = 1'b0;
`endif
    assign seq_op_s = valid_i && (ALUOp_i == 2'b11) && ((funct_i == FUNCT_MUL) || is_div_s);

    // Shift-add multiply step: multiplicand walks left, multiplier walks right
    always_comb begin
        mul_acc_s = acc_q;
        if (op_b_q[0]) begin
            mul_acc_s = acc_q + op_a_q;
        end else begin
            mul_acc_s = acc_q;
        end
        mul_a_s = {op_a_q[DATA_W-2:0], 1'b0};
        mul_b_s = {1'b0, op_b_q[DATA_W-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    logic              div_mode_q, div_mode_d;
    logic [DATA_W:0]   rem_shift_s;
    logic [DATA_W-1:0] rem_sub_s;
    logic              rem_ge_s;
    logic [DATA_W-1:0] div_acc_s;
    logic [DATA_W-1:0] div_a_s;

    // Restoring divide step: dividend bits shift out of op_a into the remainder,
    // quotient bits shift in behind them. A zero divisor yields all ones naturally.
    always_comb begin
        rem_shift_s = {acc_q, op_a_q[DATA_W-1]};
        rem_sub_s   = rem_shift_s[DATA_W-1:0] - op_b_q;
        rem_ge_s    = (rem_shift_s >= {1'b0, op_b_q});
        if (rem_ge_s) begin
            div_acc_s = rem_sub_s;
        end else begin
            div_acc_s = rem_shift_s[DATA_W-1:0];
        end
        div_a_s = {op_a_q[DATA_W-2:0], rem_ge_s};
    end
`endif

    // Sequencer next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        div_mode_d = div_mode_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (seq_op_s) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(DATA_W);
                    op_a_d  = rs_data_i;
                    op_b_d  = rt_data_i;
                    acc_d   = {DATA_W{1'b0}};
`ifdef ALU_SEQ_DIV_EN
                    div_mode_d = is_div_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
`ifdef ALU_SEQ_DIV_EN
                if (div_mode_q) begin
                    acc_d  = div_acc_s;
                    op_a_d = div_a_s;
                end else begin
                    acc_d  = mul_acc_s;
                    op_a_d = mul_a_s;
                    op_b_d = mul_b_s;
                end
`else
                acc_d  = mul_acc_s;
                op_a_d = mul_a_s;
                op_b_d = mul_b_s;
`endif
                // Last iteration: publish the result so it is valid during DONE
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
`ifdef ALU_SEQ_DIV_EN
                    if (div_mode_q) begin
                        result_d = div_a_s;
                    end else begin
                        result_d = mul_acc_s;
                    end
`else
                    result_d = mul_acc_s;
`endif
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_a_q   <= {DATA_W{1'b0}};
            op_b_q   <= {DATA_W{1'b0}};
            acc_q    <= {DATA_W{1'b0}};
            result_q <= {DATA_W{1'b0}};
            done_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_mode_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_DIV_EN
            div_mode_q <= div_mode_d;
`endif
        end
    end

    assign stall_o      = (((state_q == ST_IDLE) || (state_q == ST_DONE)) && seq_op_s)
                          || (state_q == ST_BUSY);
    assign done_o       = done_q;
    assign seq_result_o = result_q;

endmodule
